byte_unstriping: RTL

// Receive-side counterpart of the 4-lane byte striper. Accepts one 32-bit word per

---
 rtl/byte_unstriping.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/byte_unstriping.sv
// rtl/byte_unstriping.sv - 4-lane word FIFO re-serialized into a lane0-first byte stream
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   lane0..lane3           incoming word bytes; lane0 leaves first
//   in_valid / in_ready    word handshake (in_ready = FIFO not full)
//   rx_data / rx_valid     serialized byte output
//   rx_ready               sink accepts rx_data this cycle
//   word_count             words waiting in the FIFO (word in serializer not counted)
//   overflow               sticky: a word was offered while in_ready was low
module byte_unstriping #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               lane0,
    input  logic [7:0]               lane1,
    input  logic [7:0]               lane2,
    input  logic [7:0]               lane3,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   hold_q, hold_d;
    logic          push;
    logic          pop;

    // in_ready comes only from registers, so a pop in the same cycle does
    // not open a slot for a push while full.
    assign in_ready   = (count_q != FULL);
    assign push       = in_valid && in_ready;
    assign word_count = count_q;
    assign overflow   = overflow_q;
    assign rx_valid   = (state_q == SEND);

    always_comb begin
        rx_data = 8'h00;
        if (state_q == SEND) begin
            case (idx_q)
                2'd0:    rx_data = hold_q[7:0];
                2'd1:    rx_data = hold_q[15:8];
                2'd2:    rx_data = hold_q[23:16];
                default: rx_data = hold_q[31:24];
            endcase
        end
    end

    // Serializer: the head word is moved into hold_q when popped, so the
    // FIFO slot frees up as soon as the word starts going out.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    hold_d  = mem[rd_ptr_q];
                    pop     = 1'b1;
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (rx_ready) begin
                    if (idx_q != 2'd3) begin
                        idx_d = idx_q + 2'd1;
                    end else if (count_q != '0) begin
                        // chain straight into the next word: no idle bubble
                        hold_d = mem[rd_ptr_q];
                        pop    = 1'b1;
                        idx_d  = 2'd0;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (in_valid & ~in_ready);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            hold_q     <= 32'h0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
        end
    end

    // Storage array needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {lane3, lane2, lane1, lane0};
    end

endmodule
